// File: rtl/result_tx_pkg.sv
// result_tx_pkg: shared FSM states and framing constants for the result UART transmitter.
package result_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_e;
    localparam int BYTES_PER_WORD = 2;
    localparam int BITS_PER_BYTE = 8;
    localparam int BYTE_BITS_8N1 = 10;
    localparam int BYTE_BITS_8E1 = 11;
    localparam int WORD_BITS_8N1 = BYTES_PER_WORD * BYTE_BITS_8N1;
    localparam int WORD_BITS_8E1 = BYTES_PER_WORD * BYTE_BITS_8E1;
    function automatic int word_frame_clks(input int clks_per_bit, input bit parity);
        return (parity ? WORD_BITS_8E1 : WORD_BITS_8N1) * clks_per_bit;
    endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: small synchronous FIFO with async active-high reset; push when full and pop when empty are ignored.
module result_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers CPU result words and sends each as two UART bytes, high byte first.
// Define RESULT_TX_PARITY_EN to add an even-parity bit after the data bits (8E1 instead of 8N1).
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              tx,
    output logic              busy,
    output logic              overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e         state_q;
    logic [BW-1:0]     baud_q;
    logic [2:0]        bit_q;
    logic              hi_q;
    logic [DATA_W-1:0] shift_q;
    logic              tx_q;
    logic              overflow_q;
    logic [DATA_W-1:0] head;
    logic              full, empty, pop, bit_end;
    logic [CW-1:0]     count;
    logic [7:0]        cur_byte;

    assign pop      = enable && state_q == IDLE && !empty;
    assign bit_end  = baud_q == BAUD_LAST;
    assign cur_byte = hi_q ? shift_q[DATA_W-1 -: BITS_PER_BYTE] : shift_q[BITS_PER_BYTE-1:0];
    assign wr_ready = !full;
    assign busy     = state_q != IDLE || count != '0;
    assign tx       = tx_q;
    assign overflow = overflow_q;

    result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_valid),
        .pop_i   (pop),
        .data_i  (wr_data),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow_q <= 1'b0;
        else if (wr_valid && full) overflow_q <= 1'b1;
    end

    // tx is updated on the same edge as the state it belongs to, so the line is registered and glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b1;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        hi_q    <= 1'b1;
                        baud_q  <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    baud_q <= bit_end ? '0 : baud_q + 1'b1;
                    if (bit_end) begin
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= cur_byte[0];
                    end
                end
                DATA: begin
                    baud_q <= bit_end ? '0 : baud_q + 1'b1;
                    if (bit_end && bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
                        state_q <= PARITY;
                        tx_q    <= ^cur_byte;
`else
                        state_q <= STOP;
                        tx_q    <= 1'b1;
`endif
                    end else if (bit_end) begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= cur_byte[bit_q + 3'd1];
                    end
                end
`ifdef RESULT_TX_PARITY_EN
                PARITY: begin
                    baud_q <= bit_end ? '0 : baud_q + 1'b1;
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    baud_q <= bit_end ? '0 : baud_q + 1'b1;
                    if (bit_end) begin
                        hi_q    <= 1'b0;
                        state_q <= hi_q ? START : IDLE;
                        tx_q    <= !hi_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule
